// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared widths, response-state encoding and
// default starvation limit for the unified SRAM arbiter.
package sram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_INST = 2'd1,
    R_DATA = 2'd2
  } resp_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: inst/data requester buses plus the unified SRAM port.
// slave = arbiter side; master = pipeline stages and SRAM macro side.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              sram_en;
  logic [STRB_W-1:0] sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb,
    input  data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb,
    output data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/sram_arbiter_starve_counter.sv
// starve_counter: counts consecutive denied inst cycles, saturating at
// LIMIT; starve flags that inst must win the next contested grant.
module starve_counter
  import sram_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic grant_inst,
  output logic starve
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  assign starve = (cnt == LIM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!inst_req || grant_inst) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: one-request-per-cycle arbiter of a single-port SRAM
// between fetch (read) and data (r/w); data first, starvation-bounded.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic          clk,
  input logic          resetn,
  sram_arbiter_if.slave bus
);

  logic  starve;
  logic  grant_inst;
  logic  grant_data;
  resp_e resp_state;

  // Grants are gated by reset so nothing reaches the SRAM while held.
  assign grant_inst = resetn & bus.inst_req &
                      (~bus.data_req | starve);
  assign grant_data = resetn & bus.data_req & ~grant_inst;

  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;
  assign bus.sram_en      = grant_inst | grant_data;

  always_comb begin
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    bus.sram_we    = '0;
    unique case (1'b1)
      grant_inst: begin
        bus.sram_addr  = bus.inst_addr;
        bus.sram_wdata = bus.data_wdata;
      end
      grant_data: begin
        bus.sram_addr  = bus.data_addr;
        bus.sram_wdata = bus.data_wdata;
        bus.sram_we    = bus.data_wr ? bus.data_wstrb : '0;
      end
      default: ;
    endcase
  end

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (bus.inst_req),
    .grant_inst (grant_inst),
    .starve     (starve)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_state <= R_NONE;
    end else if (grant_inst) begin
      resp_state <= R_INST;
    end else if (grant_data) begin
      resp_state <= R_DATA;
    end else begin
      resp_state <= R_NONE;
    end
  end

  assign bus.inst_data_ok = (resp_state == R_INST);
  assign bus.data_data_ok = (resp_state == R_DATA);
  assign bus.inst_rdata   = bus.inst_data_ok ? bus.sram_rdata : '0;
  assign bus.data_rdata   = bus.data_data_ok ? bus.sram_rdata : '0;

endmodule
